uc_multiplier8bitsc2: RTL and testbench
=======================================

# uc_multiplier8bitsc2

Control unit for the 8-bit two's-complement multiplier datapath `FD_multiplier8bitsc2`. It is the sequencer that drives the datapath's load enables and mux selects, replacing hand-driven stimulus. On a `START` request it steps through the fixed load sequence, inserting programmable ROM-settle cycles before every ROM-sourced load, then pulses `PRONTO` when `result` is valid. It sits beside the datapath in the multiplier top, and its outputs connect one-to-one to the datapath control inputs.

## Interface
- `ROM_WAIT`, default 1: settle cycles before each ROM-sourced load, with `SELROM` driven and the load enable low. Legal range 0..7.

- `CLK`  in  1  system clock; all state changes on the rising edge
- `RESET`  in  1  asynchronous, active-high reset
- `START`  in  1  request a multiplication; sampled only in IDLE
- `LD_XY`  out  1  load operand registers x, y
- `LD_DE0`  out  1  load DE0 from ROM (SELROM=0)
- `LD_A`  out  1  load A from ROM (SELROM=1)
- `LD_B`  out  1  load B from ROM (SELROM=2)
- `LD_DE1`  out  1  load DE1 from ROM (SELROM=3)
- `LD_AB`  out  1  load A+B sum (SELSOMA=1)
- `LD_DE_ABshift`  out  1  load DE plus shifted AB (SELSOMA=2)
- `LD_RES`  out  1  load final result (SELSOMA=3)
- `SELROM`  out  2  ROM address/select
- `SELSOMA`  out  2  adder operand select
- `BUSY`  out  1  high from the first cycle after START acceptance through the LD_RES cycle
- `PRONTO`  out  1  one-cycle pulse: result register valid

## Operation
- Moore FSM. Outputs decode from state only. No output depends combinationally on `START`.
- States, in order: IDLE, XY, W_DE0, DE0, W_A, A, W_B, B, W_DE1, DE1, AB, ABSH, RES, DONE.
- A 3-bit wait counter governs each W_* state:
  - The counter loads 0 on entry.
  - The FSM leaves the W_* state when the count reaches ROM_WAIT-1.
  - If ROM_WAIT=0, every W_* state is skipped, for example XY→DE0 directly.
- Output decode per state (all signals not listed are 0):
  - IDLE: all 0.
  - XY: LD_XY=1.
  - W_DE0: SELROM=0.
  - DE0: LD_DE0=1, SELROM=0.
  - W_A: SELROM=1.
  - A: LD_A=1, SELROM=1.
  - W_B: SELROM=2.
  - B: LD_B=1, SELROM=2.
  - W_DE1: SELROM=3.
  - DE1: LD_DE1=1, SELROM=3.
  - AB: LD_AB=1, SELSOMA=1.
  - ABSH: LD_DE_ABshift=1, SELSOMA=2.
  - RES: LD_RES=1, SELSOMA=3.
  - DONE: PRONTO=1.
- BUSY=1 in every state except IDLE and DONE.
- Transitions:
  - IDLE→XY when START=1 at the clock edge, otherwise stay in IDLE.
  - Every non-wait state advances unconditionally after one cycle.
  - DONE→IDLE unconditionally.
- Exactly one LD_* is high in any cycle, and no LD_* is ever high in IDLE, W_* or DONE.
- `START` outside IDLE is ignored and is not queued.
- `START` held high continuously causes back-to-back operations: DONE→IDLE→XY, so one IDLE cycle separates operations.

## Timing
- Reset value of every output is 0, with state IDLE and counter 0. The reset acts immediately and does not wait for a clock edge.
- RESET mid-operation aborts the sequence: all LD_* and selects drop to 0 asynchronously. The datapath result register is not cleared by this block.
- Take START sampled high at edge 0. Cycle n below is the cycle following edge n-1.
  - LD_XY is high in cycle 1.
  - With W = ROM_WAIT:
    - LD_DE0 is high in cycle 2+W.
    - LD_A is high in cycle 3+2W.
    - LD_B is high in cycle 4+3W.
    - LD_DE1 is high in cycle 5+4W.
    - LD_AB is high in cycle 6+4W.
    - LD_DE_ABshift is high in cycle 7+4W.
    - LD_RES is high in cycle 8+4W.
    - PRONTO is high in cycle 9+4W.
  - W=1 gives PRONTO in cycle 13. W=0 gives PRONTO in cycle 9.
- The earliest next acceptance is the IDLE cycle, 10+4W. Minimum START-to-START period is 10+4W cycles.
- `result` from the datapath is valid from the PRONTO cycle onward and stays valid until the next LD_RES.

## Test plan
- Reset/idle:
  - Stimulus: assert RESET for 2 cycles, then hold START=0 for 20 cycles.
  - Required: all outputs stay 0 and BUSY stays 0.
- Nominal sequence, ROM_WAIT=1:
  - Stimulus: pulse START for one cycle.
  - Required: LD_XY, LD_DE0, LD_A, LD_B, LD_DE1, LD_AB, LD_DE_ABshift and LD_RES go high in cycles 1, 3, 5, 7, 9, 10, 11, 12; PRONTO goes high in cycle 13. SELROM reads 0,0,1,1,2,2,3,3 over cycles 2–9. LD_* are one-hot or zero in every cycle.
- Integrated with FD_multiplier8bitsc2:
  - Stimulus: x=14, y=8, then START.
  - Required: result=112 at PRONTO.
  - Stimulus: x=-3 (8'hFD), y=5.
  - Required: result=16'hFFF1.
- ROM_WAIT=0:
  - Stimulus: pulse START.
  - Required: PRONTO in cycle 9, and no cycle has SELROM≠0 with every LD_* low.
- Reset mid-operation:
  - Stimulus: assert RESET asynchronously in the cycle where LD_B is high, then release it.
  - Required: all outputs drop immediately with no PRONTO; a fresh START then completes normally.
- START abuse:
  - Stimulus: pulse START again while BUSY.
  - Required: the pulse is ignored and only one PRONTO is produced.
  - Stimulus: hold START high continuously.
  - Required: PRONTO pulses every 10+4W cycles.

Source files
------------

// File: rtl/uc_multiplier8bitsc2.sv
// uc_multiplier8bitsc2: Moore sequencer for the FD_multiplier8bitsc2 datapath, stepping
// through operand, ROM and adder loads with programmable ROM-settle wait states.
module uc_multiplier8bitsc2 #(
   parameter int ROM_WAIT = 1
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       START,
   output logic       LD_XY,
   output logic       LD_DE0,
   output logic       LD_A,
   output logic       LD_B,
   output logic       LD_DE1,
   output logic       LD_AB,
   output logic       LD_DE_ABshift,
   output logic       LD_RES,
   output logic [1:0] SELROM,
   output logic [1:0] SELSOMA,
   output logic       BUSY,
   output logic       PRONTO
);
   localparam logic [3:0] IDLE  = 4'd0;
   localparam logic [3:0] XY    = 4'd1;
   localparam logic [3:0] W_DE0 = 4'd2;
   localparam logic [3:0] DE0   = 4'd3;
   localparam logic [3:0] W_A   = 4'd4;
   localparam logic [3:0] A     = 4'd5;
   localparam logic [3:0] W_B   = 4'd6;
   localparam logic [3:0] B     = 4'd7;
   localparam logic [3:0] W_DE1 = 4'd8;
   localparam logic [3:0] DE1   = 4'd9;
   localparam logic [3:0] AB    = 4'd10;
   localparam logic [3:0] ABSH  = 4'd11;
   localparam logic [3:0] RES   = 4'd12;
   localparam logic [3:0] DONE  = 4'd13;
   localparam logic [2:0] LAST  = 3'(ROM_WAIT - 1);
   localparam logic       SKIP  = ROM_WAIT == 0;
   logic [3:0] state, nxt;
   logic [2:0] cnt;
   logic       is_w, pre_rom;
   assign is_w    = state inside {W_DE0, W_A, W_B, W_DE1};
   assign pre_rom = state inside {XY, DE0, A, B};
   // Each wait state sits between its two neighbours in the encoding, so skipping it is +2
   always_comb begin
      nxt = state + 4'd1;
      if (state == IDLE)
         nxt = START ? XY : IDLE;
      else if (state == DONE)
         nxt = IDLE;
      else if (is_w)
         nxt = (cnt == LAST) ? state + 4'd1 : state;
      else if (SKIP && pre_rom)
         nxt = state + 4'd2;
   end
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         cnt   <= 3'd0;
      end else begin
         state <= nxt;
         cnt   <= is_w ? cnt + 3'd1 : 3'd0;
      end
   end
   assign LD_XY         = state == XY;
   assign LD_DE0        = state == DE0;
   assign LD_A          = state == A;
   assign LD_B          = state == B;
   assign LD_DE1        = state == DE1;
   assign LD_AB         = state == AB;
   assign LD_DE_ABshift = state == ABSH;
   assign LD_RES        = state == RES;
   assign SELROM        = (state >= W_DE0 && state <= DE1) ? 2'((state - W_DE0) >> 1) : 2'd0;
   assign SELSOMA       = (state >= AB && state <= RES) ? 2'(state - DE1) : 2'd0;
   assign BUSY          = state != IDLE && state != DONE;
   assign PRONTO        = state == DONE;
endmodule

// File: tb/tb_uc_multiplier8bitsc2.sv
// tb_uc_multiplier8bitsc2: three sequencers (ROM_WAIT 1, 0, 3) driven in parallel, checked
// against a cycle-offset schedule model and a PRONTO scoreboard.
module tb_uc_multiplier8bitsc2;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   pend [3];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   // Expected {LD x8, SELROM, SELSOMA, BUSY, PRONTO} in cycle n after acceptance
   function automatic logic [13:0] expv(int n, int w);
      logic [7:0] ld;
      logic [1:0] sr, ss;
      logic       busy, pr;
      ld   = '0;
      sr   = '0;
      ss   = '0;
      busy = n >= 1 && n <= 8 + 4 * w;
      pr   = n == 9 + 4 * w;
      if (n == 1) ld[7] = 1'b1;
      for (int r = 0; r < 4; r++) begin
         int b;
         b = 2 + r * (w + 1);
         if (n >= b && n <= b + w) sr = r[1:0];
         if (n == b + w) ld[6 - r] = 1'b1;
      end
      if (n >= 6 + 4 * w && n <= 8 + 4 * w) begin
         ss = 2'(n - 5 - 4 * w);
         ld[8 + 4 * w - n] = 1'b1;
      end
      return {ld, sr, ss, busy, pr};
   endfunction
   for (genvar g = 0; g < 3; g++) begin : inst
      localparam int W = g == 0 ? 1 : g == 1 ? 0 : 3;
      logic       ld_xy, ld_de0, ld_a, ld_b, ld_de1, ld_ab, ld_desh, ld_res, busy, pronto;
      logic [1:0] sel_rom, sel_soma;
      logic [13:0] o;
      int  acc = 0;
      bit  act = 1'b0;
      int  pq[$];
      assign o = {ld_xy, ld_de0, ld_a, ld_b, ld_de1, ld_ab, ld_desh, ld_res, sel_rom, sel_soma, busy, pronto};
      uc_multiplier8bitsc2 #(.ROM_WAIT(W)) dut (
         .CLK(clk), .RESET(rst), .START(start),
         .LD_XY(ld_xy), .LD_DE0(ld_de0), .LD_A(ld_a), .LD_B(ld_b), .LD_DE1(ld_de1),
         .LD_AB(ld_ab), .LD_DE_ABshift(ld_desh), .LD_RES(ld_res),
         .SELROM(sel_rom), .SELSOMA(sel_soma), .BUSY(busy), .PRONTO(pronto)
      );
      // Acceptance only when the previous operation has reached its trailing IDLE cycle
      always @(posedge clk) begin
         if (!rst && start && (!act || cyc - acc >= 10 + 4 * W)) begin
            act = 1'b1;
            acc = cyc;
            pq.push_back(cyc + 9 + 4 * W);
         end
      end
      always @(posedge rst) begin
         act = 1'b0;
         pq.delete();
         #1;
         total++;
         if (o !== 14'd0) begin
            bad++;
            $display("FAIL async_reset w=%0d got=%h want=0", W, o);
         end
      end
      always @(negedge clk) begin
         logic [13:0] e;
         int t;
         e = expv(act ? cyc - acc : 0, W);
         total++;
         if (o !== e) begin
            bad++;
            $display("FAIL outputs w=%0d cyc=%0d got=%h want=%h", W, cyc, o, e);
         end
         if (pronto === 1'b1) begin
            total++;
            if (pq.size() == 0) begin
               bad++;
               $display("FAIL pronto_spurious w=%0d cyc=%0d got=1 want=0", W, cyc);
            end else begin
               t = pq.pop_front();
               if (t != cyc) begin
                  bad++;
                  $display("FAIL pronto_time w=%0d got=%0d want=%0d", W, cyc, t);
               end
            end
         end
         pend[g] = pq.size();
      end
   end
   task automatic pulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic async_reset();
      #2 rst = 1'b1;
      #2 rst = 1'b0;
   endtask
   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      pulse();
      repeat (30) @(negedge clk);
      pulse();
      repeat (4) @(negedge clk);
      pulse();
      repeat (30) @(negedge clk);
      pulse();
      repeat (6) @(negedge clk);
      async_reset();
      repeat (2) @(negedge clk);
      pulse();
      repeat (30) @(negedge clk);
      start = 1'b1;
      repeat (60) @(negedge clk);
      start = 1'b0;
      repeat (30) @(negedge clk);
      for (int i = 0; i < 400; i++) begin
         start = $urandom_range(0, 3) == 0;
         if ($urandom_range(0, 59) == 0) async_reset();
         @(negedge clk);
      end
      start = 1'b0;
      repeat (40) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         total++;
         if (pend[i] != 0) begin
            bad++;
            $display("FAIL pronto_missing inst=%0d got_pending=%0d want=0", i, pend[i]);
         end
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
